// File: rtl/pwm_ctrl_pkg.sv
// Shared types and helpers for the PWM level controller.
package pwm_ctrl_pkg;

    // Sequencer states: value setup, strobe high, strobe low, idle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        LOAD  = 2'd2,
        GAP   = 2'd3
    } state_t;

    // Bits needed to count down from max(load_hold, gap_cycles).
    function automatic int cnt_width(input int load_hold, input int gap_cycles);
        int m;
        int w;
        m = (load_hold > gap_cycles) ? load_hold : gap_cycles;
        w = 1;
        while ((1 << w) <= m) w++;
        return w;
    endfunction

    // Counter width for the default hold/gap settings.
    localparam int CNT_W_DEFAULT = cnt_width(4, 2);

    // Unsigned clamp; callers zero-extend their levels to 32 bits.
    function automatic logic [31:0] clamp_level(input logic [31:0] v,
                                                input logic [31:0] lo,
                                                input logic [31:0] hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/pwm_level_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or after ptr.
module rr_arbiter
    import pwm_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_grant
);

    // Scan NUM_REQ positions starting at ptr, wrapping, and take the first hit.
    always_comb begin
        int j;
        j         = 0;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(ptr) + i) % NUM_REQ;
            if (!any_grant && req[j]) begin
                any_grant = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/pwm_level_ctrl.sv
// Brightness update sequencer feeding a PWM dimmer through a shared
// load/value port, with round-robin requesters and display on/off handling.
module pwm_level_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int PWM_WIDTH  = 12,
    parameter int NUM_REQ    = 3,
    parameter int LOAD_HOLD  = 4,
    parameter int GAP_CYCLES = 2,
    parameter int MIN_LEVEL  = 16,
    parameter int MAX_LEVEL  = 4095
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         enable,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*PWM_WIDTH-1:0] req_value,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         pwm_load,
    output logic [PWM_WIDTH-1:0]         pwm_value,
    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   active_src
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = cnt_width(LOAD_HOLD, GAP_CYCLES);

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic                 applied_on;
    logic [PWM_WIDTH-1:0] last_level;
    logic [IDX_W-1:0]     rr_ptr;

    logic [NUM_REQ-1:0]   grant;
    logic [IDX_W-1:0]     grant_idx;
    logic                 any_grant;
    logic [PWM_WIDTH-1:0] granted_raw;
    logic [PWM_WIDTH-1:0] granted_level;
    logic [IDX_W-1:0]     next_ptr;
    logic                 force_pending;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // A pending on/off change outranks any request in IDLE.
    assign force_pending = (enable != applied_on);

    assign granted_raw   = req_value[int'(grant_idx)*PWM_WIDTH +: PWM_WIDTH];
    assign granted_level = PWM_WIDTH'(clamp_level(32'(granted_raw),
                                                  32'(MIN_LEVEL),
                                                  32'(MAX_LEVEL)));
    assign next_ptr      = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    // Grant is visible in the accepting cycle so the requester can drop valid
    // before the next IDLE cycle; no grant while a force sequence is due.
    assign req_ready = (reset_n && state == IDLE && !force_pending) ? grant : '0;
    assign busy      = (state != IDLE);

    // Sequencer FSM: pwm_value is set on entry to SETUP, then the strobe is
    // held for LOAD_HOLD cycles and kept low for GAP_CYCLES cycles.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            applied_on <= 1'b0;
            last_level <= '0;
            rr_ptr     <= '0;
            pwm_load   <= 1'b0;
            pwm_value  <= '0;
            active_src <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (force_pending) begin
                        applied_on <= enable;
                        pwm_value  <= enable ? last_level : '0;
                        state      <= SETUP;
                    end else if (any_grant) begin
                        last_level <= granted_level;
                        active_src <= grant_idx;
                        rr_ptr     <= next_ptr;
                        if (applied_on) begin
                            pwm_value <= granted_level;
                            state     <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    pwm_load <= 1'b1;
                    cnt      <= CNT_W'(LOAD_HOLD - 1);
                    state    <= LOAD;
                end
                LOAD: begin
                    if (cnt == '0) begin
                        pwm_load <= 1'b0;
                        cnt      <= CNT_W'(GAP_CYCLES - 1);
                        state    <= GAP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == '0) state <= IDLE;
                    else           cnt   <= cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_level_ctrl.sv
// Directed bench for pwm_level_ctrl: reset restore, grants, clamping,
// round-robin spacing and enable handling.
module tb_pwm_level_ctrl;

    localparam int PW = 12;
    localparam int NR = 3;

    logic             clock;
    logic             reset_n;
    logic             enable;
    logic [NR-1:0]    req_valid;
    logic [NR*PW-1:0] req_value;
    logic [NR-1:0]    req_ready;
    logic             pwm_load;
    logic [PW-1:0]    pwm_value;
    logic             busy;
    logic [1:0]       active_src;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int load_vals[$];
    int load_lens[$];
    int load_start[$];
    int grant_src[$];
    int grant_cyc[$];
    int rise_cyc;
    int rise_val;
    logic load_prev = 1'b0;

    pwm_level_ctrl #(
        .PWM_WIDTH  (PW),
        .NUM_REQ    (NR),
        .LOAD_HOLD  (4),
        .GAP_CYCLES (2),
        .MIN_LEVEL  (16),
        .MAX_LEVEL  (12'hFF0)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .req_valid  (req_valid),
        .req_value  (req_value),
        .req_ready  (req_ready),
        .pwm_load   (pwm_load),
        .pwm_value  (pwm_value),
        .busy       (busy),
        .active_src (active_src)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    // Record every load strobe (value, start cycle, length) and every grant.
    always @(negedge clock) begin
        if (pwm_load && !load_prev) begin
            rise_cyc = cyc;
            rise_val = int'(pwm_value);
        end
        if (!pwm_load && load_prev) begin
            load_vals.push_back(rise_val);
            load_start.push_back(rise_cyc);
            load_lens.push_back(cyc - rise_cyc);
        end
        load_prev = pwm_load;
        if (req_ready != '0) begin
            for (int k = 0; k < NR; k++)
                if (req_ready[k]) grant_src.push_back(k);
            grant_cyc.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_log();
        load_vals.delete();
        load_lens.delete();
        load_start.delete();
        grant_src.delete();
        grant_cyc.delete();
    endtask

    // Present one request, wait (bounded) for its grant, then drop valid.
    task automatic do_req(input int idx, input int val, output int gcyc);
        bit got;
        got  = 1'b0;
        gcyc = -1;
        req_value[idx*PW +: PW] = PW'(val);
        req_valid[idx] = 1'b1;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clock);
            if (req_ready[idx]) begin
                got  = 1'b1;
                gcyc = cyc;
            end
        end
        check_eq("grant_seen", 32'(got), 32'd1);
        @(posedge clock);
        #1;
        req_valid[idx] = 1'b0;
    endtask

    function automatic int qv(input int q[$], input int i);
        return (q.size() > i) ? q[i] : -1;
    endfunction

    initial begin
        int g;
        int rel;
        reset_n   = 1'b0;
        enable    = 1'b1;
        req_valid = '0;
        req_value = '0;

        // Reset state
        step(3);
        @(negedge clock);
        check_eq("rst_load",   32'(pwm_load),   32'd0);
        check_eq("rst_value",  32'(pwm_value),  32'd0);
        check_eq("rst_ready",  32'(req_ready),  32'd0);
        check_eq("rst_busy",   32'(busy),       32'd0);
        check_eq("rst_src",    32'(active_src), 32'd0);

        // Restore sequence out of reset with enable=1
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        rel = cyc;
        clear_log();
        step(12);
        check_eq("restore_cnt",   32'(load_vals.size()), 32'd1);
        check_eq("restore_val",   32'(qv(load_vals, 0)), 32'd0);
        check_eq("restore_len",   32'(qv(load_lens, 0)), 32'd4);
        check_eq("restore_start", 32'(qv(load_start, 0)), 32'(rel + 2));
        check_eq("restore_idle",  32'(busy), 32'd0);

        // Single request, value 0x800
        clear_log();
        do_req(0, 'h800, g);
        @(negedge clock);
        check_eq("req0_value_t1", 32'(pwm_value), 32'h800);
        check_eq("req0_load_t1",  32'(pwm_load),  32'd0);
        check_eq("req0_src",      32'(active_src), 32'd0);
        step(12);
        check_eq("req0_val",   32'(qv(load_vals, 0)), 32'h800);
        check_eq("req0_len",   32'(qv(load_lens, 0)), 32'd4);
        check_eq("req0_start", 32'(qv(load_start, 0)), 32'(g + 2));

        // Clamping at both ends
        clear_log();
        do_req(1, 'h005, g);
        step(12);
        check_eq("clamp_lo", 32'(qv(load_vals, 0)), 32'h010);
        check_eq("clamp_lo_src", 32'(active_src), 32'd1);
        do_req(2, 'hFFF, g);
        step(12);
        check_eq("clamp_hi", 32'(qv(load_vals, 1)), 32'hFF0);
        check_eq("clamp_hi_src", 32'(active_src), 32'd2);

        // All requesters valid continuously
        clear_log();
        req_value = {12'h300, 12'h200, 12'h100};
        req_valid = 3'b111;
        step(30);
        req_valid = '0;
        step(12);
        check_eq("rr_count_ge4", 32'(grant_src.size() >= 4), 32'd1);
        check_eq("rr_g0", 32'(qv(grant_src, 0)), 32'd0);
        check_eq("rr_g1", 32'(qv(grant_src, 1)), 32'd1);
        check_eq("rr_g2", 32'(qv(grant_src, 2)), 32'd2);
        check_eq("rr_g3", 32'(qv(grant_src, 3)), 32'd0);
        for (int k = 1; k < 4; k++)
            check_eq("rr_spacing", 32'(qv(grant_cyc, k) - qv(grant_cyc, k - 1)), 32'd8);
        check_eq("rr_v0", 32'(qv(load_vals, 0)), 32'h100);
        check_eq("rr_v1", 32'(qv(load_vals, 1)), 32'h200);
        check_eq("rr_v2", 32'(qv(load_vals, 2)), 32'h300);

        // Enable dropped during LOAD of 0x400
        clear_log();
        do_req(0, 'h400, g);
        step(1);
        enable = 1'b0;
        step(20);
        check_eq("off_cnt",   32'(load_vals.size()), 32'd2);
        check_eq("off_v0",    32'(qv(load_vals, 0)), 32'h400);
        check_eq("off_len0",  32'(qv(load_lens, 0)), 32'd4);
        check_eq("off_v1",    32'(qv(load_vals, 1)), 32'd0);
        check_eq("off_start", 32'(qv(load_start, 1)), 32'(g + 10));
        clear_log();
        do_req(1, 'h500, g);
        step(10);
        check_eq("off_req_noload", 32'(load_vals.size()), 32'd0);
        check_eq("off_req_src",    32'(active_src), 32'd1);
        enable = 1'b1;
        step(12);
        check_eq("on_restore_cnt", 32'(load_vals.size()), 32'd1);
        check_eq("on_restore_val", 32'(qv(load_vals, 0)), 32'h500);

        // Enable pulsed low inside a sequence collapses to nothing
        clear_log();
        do_req(2, 'h600, g);
        enable = 1'b0;
        step(2);
        enable = 1'b1;
        step(20);
        check_eq("pulse_cnt", 32'(load_vals.size()), 32'd1);
        check_eq("pulse_val", 32'(qv(load_vals, 0)), 32'h600);

        // Reset mid-LOAD
        do_req(0, 'h700, g);
        step(1);
        @(negedge clock);
        check_eq("midrst_load_before", 32'(pwm_load), 32'd1);
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        @(negedge clock);
        check_eq("midrst_load_held", 32'(pwm_load), 32'd1);
        @(negedge clock);
        check_eq("midrst_load",  32'(pwm_load),   32'd0);
        check_eq("midrst_value", 32'(pwm_value),  32'd0);
        check_eq("midrst_src",   32'(active_src), 32'd0);
        check_eq("midrst_busy",  32'(busy),       32'd0);
        check_eq("midrst_ready", 32'(req_ready),  32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        step(12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
